multi_channel_audio_fifo: RTL and testbench
===========================================

// Module: multi_channel_audio_fifo
// PURPOSE
// - Per-channel circular sample FIFO for the DAW track engine. CHANNELS independent queues share one
//   block RAM, addressed as {channel, pointer}.
// - Producers (ADC path, track loaders) write samples; the mixer pulls them.
// - Accepted reads return data exactly 2 cycles later with a valid strobe.
// - Per-channel full/empty flags, sticky error flags, per-channel flush.
// PARAMETERS
// - WIDTH     16   sample width in bits
// - DEPTH     512  entries per channel; power of two, >= 4
// - CHANNELS  4    number of independent queues; power of two, >= 1
// PORTS
// - clk         in   1                   system clock, 100 MHz
// - rst         in   1                   synchronous, active-high reset
// - wr          in   1                   write strobe; level-sensitive, one write per high cycle
// - wr_ch       in   $clog2(CHANNELS)    target channel of the write
// - din         in   WIDTH               write sample
// - rd          in   1                   read strobe; level-sensitive, one read per high cycle
// - rd_ch       in   $clog2(CHANNELS)    source channel of the read
// - flush       in   1                   empty channel flush_ch this cycle
// - flush_ch    in   $clog2(CHANNELS)    channel to flush
// - dout        out  WIDTH               read sample; meaningful only while dout_valid is high
// - dout_valid  out  1                   high for 1 cycle, 2 cycles after an accepted read
// - dout_ch     out  $clog2(CHANNELS)    channel that dout belongs to
// - full        out  CHANNELS            bit c is high when channel c count == DEPTH
// - empty       out  CHANNELS            bit c is high when channel c count == 0
// - overflow    out  1                   sticky: a write was rejected; cleared only by rst
// - underflow   out  1                   sticky: a read was rejected; cleared only by rst
// BEHAVIOUR
// - Per-channel state: wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrapping DEPTH-1 -> 0 naturally.
// - Per-channel count: $clog2(DEPTH)+1 bits. full and empty are decoded combinationally from count.
// - Acceptance uses the count from the start of the cycle:
//   - write accepted iff !full[wr_ch];
//   - read accepted iff !empty[rd_ch].
//   - An rd/wr to the same channel in the same cycle cannot rescue the other:
//     write to a full channel is still rejected; read from an empty channel is still rejected.
// - Accepted write: RAM[{wr_ch, wr_ptr}] <= din; wr_ptr++; count++.
// - Accepted read: rd_ptr++; count--.
// - Accepted read and write on the same channel in the same cycle: both pointers advance; count unchanged.
// - Read and write never hit the same address when accepted (equal pointers imply empty or full).
//   No RAM collision handling is required.
// - Read pipeline:
//   - cycle T: rd accepted;
//   - T+1: RAM output register;
//   - T+2: dout, dout_valid=1, dout_ch=rd_ch captured at T.
//   - Back-to-back reads give one sample per cycle.
// - Rejected write sets overflow; RAM and pointers untouched. Rejected read sets underflow; no dout_valid.
// - Flush:
//   - rd_ptr <= wr_ptr and count <= 0 on flush_ch.
//   - Flush beats a same-cycle wr or rd on that channel: the op is dropped, no error flag.
//   - Reads already in flight still complete.
// - Reset (any cycle, including mid-read):
//   - all pointers, counts, dout, dout_valid, dout_ch, overflow and underflow go to 0;
//   - empty = all ones, full = 0;
//   - in-flight reads are discarded; RAM contents are not cleared.
// CONFIGURATION
// - AUDIO_FIFO_UNDERRUN_SILENCE_EN defined:
//   - a rejected read still produces dout_valid at T+2, with dout = 0 (silence) and dout_ch = rd_ch;
//   - underflow is still set.
//   - The mixer then always gets one sample per request.
// - AUDIO_FIFO_UNDERRUN_SILENCE_EN undefined: a rejected read produces no dout_valid.
// TESTING
// - rst; write 0x1111,0x2222 to ch1; rd ch1 at cycles T, T+1
//   -> dout 0x1111 at T+2, 0x2222 at T+3; dout_ch=1; empty[1]=1 after the second read.
// - Fill ch0 with 512 writes -> full[0]=1, others unaffected; 513th write -> overflow=1, ch0 data intact;
//   wrap the read side through index 511 -> 0 in order.
// - rd on empty ch2 -> underflow=1; no valid without the macro; valid with dout=0 and dout_ch=2 with the macro.
// - ch3 holding 1 sample: same-cycle rd+wr ch3 -> count stays 1, old sample returned;
//   with ch3 full, same-cycle rd+wr -> write rejected, overflow=1.
// - ch1 holding 5 samples, flush ch1 with same-cycle wr ch1 -> empty[1]=1, no overflow;
//   next write/read round-trips correctly.
// - Assert rst one cycle after an accepted read -> no dout_valid; all flags at reset values; empty=4'b1111.

Source files
------------

// File: rtl/multi_channel_audio_fifo.sv
// multi_channel_audio_fifo
// CHANNELS independent circular sample queues sharing one block RAM addressed
// as {channel, pointer}. Reads return data two cycles after acceptance with a
// valid strobe and the source channel. Per-channel full/empty, sticky
// overflow/underflow, per-channel flush.
// Optional build macro: AUDIO_FIFO_UNDERRUN_SILENCE_EN -- a read rejected for
// underflow still returns a valid beat carrying a zero (silence) sample.
module multi_channel_audio_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 512,
    parameter int CHANNELS = 4,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [CHW-1:0]      wr_ch,
    input  logic [WIDTH-1:0]    din,
    input  logic                rd,
    input  logic [CHW-1:0]      rd_ch,
    input  logic                flush,
    input  logic [CHW-1:0]      flush_ch,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    output logic [CHW-1:0]      dout_ch,
    output logic [CHANNELS-1:0] full,
    output logic [CHANNELS-1:0] empty,
    output logic                overflow,
    output logic                underflow
);

    logic [PW-1:0]    wr_ptr [CHANNELS];
    logic [PW-1:0]    rd_ptr [CHANNELS];
    logic [CW-1:0]    count  [CHANNELS];
    logic [WIDTH-1:0] mem    [CHANNELS*DEPTH];

    logic             wr_flushed, rd_flushed;
    logic             wr_ok, wr_rej, rd_ok, rd_rej;
    logic             rd_issue, rd_silent;
    logic             vld_p1, sil_p1;
    logic [CHW-1:0]   ch_p1;
    logic [WIDTH-1:0] ram_p1;

    // Occupancy update for one channel; simultaneous inc and dec cancel.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur,
                                                 input logic inc, input logic dec);
        logic [CW-1:0] nxt;
        nxt = cur;
        if (inc && !dec) nxt = cur + 1'b1;
        if (dec && !inc) nxt = cur - 1'b1;
        return nxt;
    endfunction

    // Flags decoded from the start-of-cycle counts.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            full[c]  = (count[c] == CW'(DEPTH));
            empty[c] = (count[c] == '0);
        end
    end

    // A flush on the same channel silently drops the op; otherwise the
    // start-of-cycle flags alone decide, so rd and wr never rescue each other.
    assign wr_flushed = flush && (flush_ch == wr_ch);
    assign rd_flushed = flush && (flush_ch == rd_ch);
    assign wr_ok      = wr && !wr_flushed && !full[wr_ch];
    assign wr_rej     = wr && !wr_flushed &&  full[wr_ch];
    assign rd_ok      = rd && !rd_flushed && !empty[rd_ch];
    assign rd_rej     = rd && !rd_flushed &&  empty[rd_ch];

`ifdef AUDIO_FIFO_UNDERRUN_SILENCE_EN
    assign rd_issue  = rd_ok || rd_rej;
    assign rd_silent = rd_rej;
`else
    assign rd_issue  = rd_ok;
    assign rd_silent = 1'b0;
`endif

    // Pointer, count, sticky flag and read-valid control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            overflow  <= 1'b0;
            underflow <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (flush && (flush_ch == CHW'(c))) begin
                    rd_ptr[c] <= wr_ptr[c];
                    count[c]  <= '0;
                end else begin
                    if (wr_ok && (wr_ch == CHW'(c))) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (rd_ok && (rd_ch == CHW'(c))) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                    count[c] <= next_count(count[c],
                                           wr_ok && (wr_ch == CHW'(c)),
                                           rd_ok && (rd_ch == CHW'(c)));
                end
            end
            overflow  <= overflow  | wr_rej;
            underflow <= underflow | rd_rej;
            vld_p1    <= rd_issue;
        end
    end

    // ---- stage p1: RAM write port and registered RAM read ----
    always_ff @(posedge clk) begin
        if (wr_ok) mem[{wr_ch, wr_ptr[wr_ch]}] <= din;
        if (rd_issue) begin
            ram_p1 <= mem[{rd_ch, rd_ptr[rd_ch]}];
            ch_p1  <= rd_ch;
            sil_p1 <= rd_silent;
        end
    end

    // ---- stage p2: output register, silence substitution on underrun ----
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_ch    <= '0;
        end else begin
            dout_valid <= vld_p1;
            if (vld_p1) begin
                dout    <= sil_p1 ? '0 : ram_p1;
                dout_ch <= ch_p1;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_audio_fifo.sv
// Directed bench for multi_channel_audio_fifo with a per-channel reference
// queue model and an output scoreboard. Honours AUDIO_FIFO_UNDERRUN_SILENCE_EN.
module tb_multi_channel_audio_fifo;
    localparam int W = 16;
    localparam int D = 512;
    localparam int C = 4;

    logic          clk = 1'b0;
    logic          rst, wr, rd, flush;
    logic [1:0]    wr_ch, rd_ch, flush_ch;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic [1:0]    dout_ch;
    logic [C-1:0]  full, empty;
    logic          overflow, underflow;

    multi_channel_audio_fifo #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wr_ch(wr_ch), .din(din),
        .rd(rd), .rd_ch(rd_ch), .flush(flush), .flush_ch(flush_ch),
        .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [17:0]  sb [$];
    logic [W-1:0] mdata [C][D];
    int           mhead [C];
    int           mcnt  [C];
    logic         exp_ovf, exp_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [17:0] e;
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'b0, dout_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("dout_ch", {30'b0, dout_ch}, {30'b0, e[17:16]});
                check("dout", {16'b0, dout}, {16'b0, e[15:0]});
            end
        end
    endtask

    task automatic check_flags();
        logic [C-1:0] ef, ee;
        for (int c = 0; c < C; c++) begin
            ef[c] = (mcnt[c] == D);
            ee[c] = (mcnt[c] == 0);
        end
        check("full", {28'b0, full}, {28'b0, ef});
        check("empty", {28'b0, empty}, {28'b0, ee});
        check("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
        check("underflow", {31'b0, underflow}, {31'b0, exp_unf});
    endtask

    // One clock with the given strobes; the model is advanced from the
    // start-of-cycle state, then outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic we, input logic [1:0] wc, input logic [W-1:0] d,
                       input logic re, input logic [1:0] rc,
                       input logic fe, input logic [1:0] fc);
        logic wacc, wrej, racc, rrej;
        int   idx;
        wacc = we && !(fe && fc == wc) && (mcnt[wc] < D);
        wrej = we && !(fe && fc == wc) && (mcnt[wc] == D);
        racc = re && !(fe && fc == rc) && (mcnt[rc] > 0);
        rrej = re && !(fe && fc == rc) && (mcnt[rc] == 0);
        if (racc) begin
            sb.push_back({rc, mdata[rc][mhead[rc]]});
            mhead[rc] = (mhead[rc] + 1) % D;
            mcnt[rc]--;
        end
`ifdef AUDIO_FIFO_UNDERRUN_SILENCE_EN
        if (rrej) sb.push_back({rc, 16'h0000});
`endif
        if (wacc) begin
            idx = (mhead[wc] + mcnt[wc]) % D;
            mdata[wc][idx] = d;
            mcnt[wc]++;
        end
        if (fe) begin
            mhead[fc] = (mhead[fc] + mcnt[fc]) % D;
            mcnt[fc]  = 0;
        end
        exp_ovf = exp_ovf | wrej;
        exp_unf = exp_unf | rrej;
        wr = we; wr_ch = wc; din = d;
        rd = re; rd_ch = rc;
        flush = fe; flush_ch = fc;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0;
        monitor();
        check_flags();
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        for (int c = 0; c < C; c++) begin
            mhead[c] = 0;
            mcnt[c]  = 0;
        end
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        sb.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_valid", {31'b0, dout_valid}, 32'd0);
        check("rst_dout", {16'b0, dout}, 32'd0);
        check("rst_dout_ch", {30'b0, dout_ch}, 32'd0);
        check("rst_full", {28'b0, full}, 32'd0);
        check("rst_empty", {28'b0, empty}, 32'hF);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_underflow", {31'b0, underflow}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0;
        wr_ch = '0; rd_ch = '0; flush_ch = '0; din = '0;
        @(posedge clk); #1;
        do_reset();

        // Two samples through ch1 with exact two-cycle latency.
        cyc(1'b1, 2'd1, 16'h1111, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b1, 2'd1, 16'h2222, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 1'b0, 2'd0);
        check("lat_t1_valid", {31'b0, dout_valid}, 32'd0);
        cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 1'b0, 2'd0);
        check("lat_t2_valid", {31'b0, dout_valid}, 32'd1);
        check("lat_t2_dout", {16'b0, dout}, 32'h1111);
        idle();
        check("lat_t3_dout", {16'b0, dout}, 32'h2222);
        idle();
        check("lat_t4_valid", {31'b0, dout_valid}, 32'd0);

        // Fill ch0, overflow, then wrap the read side.
        do_reset();
        for (int i = 0; i < D; i++) cyc(1'b1, 2'd0, 16'(i * 7 + 3), 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b1, 2'd0, 16'hDEAD, 1'b0, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < D; i++) cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 16'(16'hA000 + i), 1'b0, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        idle(); idle();

        // Underflow on empty ch2.
        do_reset();
        cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 1'b0, 2'd0);
        idle(); idle(); idle();

        // Same-cycle rd+wr on ch3: with one sample, then with ch3 full.
        do_reset();
        cyc(1'b1, 2'd3, 16'hAAAA, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b1, 2'd3, 16'hBBBB, 1'b1, 2'd3, 1'b0, 2'd0);
        idle(); idle();
        for (int i = 0; i < D - 1; i++) cyc(1'b1, 2'd3, 16'(16'h3000 + i), 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b1, 2'd3, 16'hCCCC, 1'b1, 2'd3, 1'b0, 2'd0);
        idle(); idle();

        // Flush ch1 with a colliding write, then round-trip.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd1, 16'(16'h5100 + i), 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b1, 2'd1, 16'h5555, 1'b0, 2'd0, 1'b1, 2'd1);
        cyc(1'b1, 2'd1, 16'h7777, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 1'b0, 2'd0);
        idle(); idle(); idle();

        // Reset one cycle after an accepted read discards it.
        do_reset();
        cyc(1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 1'b0, 2'd0);
        do_reset();
        idle(); idle(); idle();

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
